// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with round-robin replacement
// and a sequential flush sweep.
// Lookup is combinational. Updates land on the rising edge, but only while idle.
// Optional feature macro: BTB_ASSOC_BHT_EN adds 2-bit direction counters per entry.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | normal operation: lookups served, commit updates applied
// S_FLUSH | sweeping one set per cycle to clear valid bits and victim pointers
module btb_assoc #(
  parameter int INDEX_BITS = 6,
  parameter int WAYS       = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_raddr,
  output logic        o_btb_hit,
  output logic        o_pred_taken,
  output logic [31:0] o_rd_data,
  input  logic        i_upd_en,
  input  logic [31:0] i_upd_pc,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_taken,
  input  logic        i_flush,
  output logic        o_flush_busy
);

  localparam int SETS  = 2 ** INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;
  localparam int VW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  generate
    if (!(WAYS == 1 || WAYS == 2 || WAYS == 4)) begin : g_bad_ways
      $error("btb_assoc: WAYS must be 1, 2 or 4");
    end
    if (INDEX_BITS < 2 || INDEX_BITS > 10) begin : g_bad_index
      $error("btb_assoc: INDEX_BITS must be in 2..10");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [INDEX_BITS-1:0]   r_sweep;

  logic                    r_valid  [SETS][WAYS];
  logic [TAG_W-1:0]        r_tag    [SETS][WAYS];
  logic [31:0]             r_target [SETS][WAYS];
`ifdef BTB_ASSOC_BHT_EN
  logic [1:0]              r_ctr    [SETS][WAYS];
`endif
  // When WAYS=1 the pointer is held at zero and never advances.
  logic [VW-1:0]           r_victim [SETS];

  logic [INDEX_BITS-1:0]   w_rd_idx, w_up_idx;
  logic [TAG_W-1:0]        w_rd_tag, w_up_tag;
  logic                    w_rd_hit, w_up_hit, w_has_free, w_hit_out;
  logic [VW-1:0]           w_rd_way, w_up_way, w_free_way, w_alloc_way;
  logic                    w_unused_bits;

  assign w_rd_idx = i_raddr[INDEX_BITS+1:2];
  assign w_rd_tag = i_raddr[31:INDEX_BITS+2];
  assign w_up_idx = i_upd_pc[INDEX_BITS+1:2];
  assign w_up_tag = i_upd_pc[31:INDEX_BITS+2];
  assign w_unused_bits = ^{i_raddr[1:0], i_upd_pc[1:0]};

  // Lookup tag compare across the ways of the read set.
  always_comb begin
    w_rd_hit = 1'b0;
    w_rd_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_rd_idx][w] && (r_tag[w_rd_idx][w] == w_rd_tag)) begin
        w_rd_hit = 1'b1;
        w_rd_way = VW'(w);
      end
    end
  end

  // Update-side tag compare plus selection of the lowest free way.
  always_comb begin
    w_up_hit   = 1'b0;
    w_up_way   = '0;
    w_has_free = 1'b0;
    w_free_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
        w_up_hit = 1'b1;
        w_up_way = VW'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_up_idx][w]) begin
        w_has_free = 1'b1;
        w_free_way = VW'(w);
      end
    end
  end

  assign w_alloc_way  = w_has_free ? w_free_way : r_victim[w_up_idx];
  assign w_hit_out    = w_rd_hit && (r_state == S_IDLE);
  assign o_btb_hit    = w_hit_out;
  assign o_rd_data    = w_hit_out ? r_target[w_rd_idx][w_rd_way] : 32'd0;
  assign o_flush_busy = (r_state == S_FLUSH);
`ifdef BTB_ASSOC_BHT_EN
  assign o_pred_taken = w_hit_out && r_ctr[w_rd_idx][w_rd_way][1];
`else
  assign o_pred_taken = w_hit_out;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic. A flush request arriving mid-sweep is ignored.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_flush) w_state_next = S_FLUSH;
      S_FLUSH: if (&r_sweep) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Sweep pointer: held at zero while idle, walks one set per flush cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_state == S_IDLE) r_sweep <= '0;
    else                            r_sweep <= r_sweep + 1'b1;
  end

  // Entry storage: reset clear, flush sweep, or commit update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SETS; s++) begin
        r_victim[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
`ifdef BTB_ASSOC_BHT_EN
          r_ctr[s][w]   <= 2'd0;
`endif
        end
      end
    end else if (r_state == S_FLUSH) begin
      r_victim[r_sweep] <= '0;
      for (int w = 0; w < WAYS; w++) r_valid[r_sweep][w] <= 1'b0;
    end else if (i_upd_en) begin
      if (w_up_hit) begin
        if (i_upd_taken) begin
          r_target[w_up_idx][w_up_way] <= i_upd_target;
`ifdef BTB_ASSOC_BHT_EN
          if (r_ctr[w_up_idx][w_up_way] != 2'd3)
            r_ctr[w_up_idx][w_up_way] <= r_ctr[w_up_idx][w_up_way] + 2'd1;
`endif
        end else begin
`ifdef BTB_ASSOC_BHT_EN
          if (r_ctr[w_up_idx][w_up_way] != 2'd0)
            r_ctr[w_up_idx][w_up_way] <= r_ctr[w_up_idx][w_up_way] - 2'd1;
`else
          // Without direction history a not-taken resolution drops the entry.
          r_valid[w_up_idx][w_up_way] <= 1'b0;
`endif
        end
      end else if (i_upd_taken) begin
        r_valid[w_up_idx][w_alloc_way]  <= 1'b1;
        r_tag[w_up_idx][w_alloc_way]    <= w_up_tag;
        r_target[w_up_idx][w_alloc_way] <= i_upd_target;
`ifdef BTB_ASSOC_BHT_EN
        r_ctr[w_up_idx][w_alloc_way]    <= 2'd2;
`endif
        if (!w_has_free && WAYS > 1)
          r_victim[w_up_idx] <= r_victim[w_up_idx] + 1'b1;
      end
    end
  end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 Parameter INDEX_BITS, default 6: set-index width; sets = 2**INDEX_BITS; legal range 2..10.
REQ-002 Parameter WAYS, default 2: ways per set; legal values 1, 2, 4; other values SHALL fail elaboration.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 raddr  input  32  fetch PC for lookup.
REQ-006 btb_hit  output  1  valid tag match for raddr.
REQ-007 pred_taken  output  1  predicted-taken for raddr.
REQ-008 rd_data  output  32  predicted target; 0 when btb_hit=0.
REQ-009 upd_en  input  1  commit-stage update strobe for a resolved branch.
REQ-010 upd_pc  input  32  PC of resolved branch.
REQ-011 upd_target  input  32  resolved target.
REQ-012 upd_taken  input  1  resolved direction.
REQ-013 flush  input  1  one-cycle request to invalidate all entries.
REQ-014 flush_busy  output  1  high while flush sweep in progress.

Function
REQ-015 Index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2]; pc[1:0] ignored.
REQ-016 Per entry: valid, tag, target, 2-bit counter; per set: round-robin victim pointer of log2(WAYS) bits (none when WAYS=1).
REQ-017 Lookup purely combinational, same cycle: btb_hit=1 iff some way of set raddr-index is valid with equal tag; rd_data = that way's target.
REQ-018 Lookup and update same cycle, same set: lookup returns pre-update contents.
REQ-019 Update applied at rising edge when upd_en=1 and FSM is IDLE; updates during FLUSH are dropped.
REQ-020 Update hit, taken: target overwritten with upd_target; counter incremented, saturating at 3.
REQ-021 Update hit, not taken: counter decremented, saturating at 0; target unchanged.
REQ-022 Update miss, taken: allocate lowest-numbered invalid way; if none invalid, replace way at victim pointer and advance pointer modulo WAYS; new entry valid, tag, target written, counter=2.
REQ-023 Update miss, not taken: no state change.
REQ-024 Allocation only on miss, so at most one way per set matches a given tag.
REQ-025 FSM states IDLE, FLUSH. IDLE->FLUSH on flush=1, sweep pointer=0. In FLUSH, each cycle clears valid and victim pointer of set[sweep], then sweep increments; FLUSH->IDLE after set 2**INDEX_BITS-1 cleared (sweep takes 2**INDEX_BITS cycles).
REQ-026 flush_busy=1 exactly while in FLUSH; btb_hit, pred_taken forced 0 and rd_data 0 during FLUSH; flush asserted during FLUSH ignored.

Reset
REQ-027 rst=1 at a rising edge clears all valid bits, counters, victim pointers, sweep pointer in one cycle; FSM -> IDLE.
REQ-028 After reset: btb_hit=0, pred_taken=0, rd_data=0, flush_busy=0; rst mid-flush aborts sweep with all entries invalid.
REQ-029 rst has priority over flush and upd_en in the same cycle.

Configuration
REQ-030 Macro BTB_ASSOC_BHT_EN defined: counters implemented; pred_taken = btb_hit & counter[1].
REQ-031 Macro undefined: no counters; pred_taken = btb_hit; update hit not-taken invalidates that entry (victim pointer unchanged); REQ-020/021 counter actions omitted.

Verification
REQ-032 Reset; raddr=0x100 -> btb_hit=0, rd_data=0, pred_taken=0, flush_busy=0.
REQ-033 Update pc=0x100 target=0x200 taken; next cycle raddr=0x100 -> hit=1, rd_data=0x200, pred_taken=1; raddr=0x102 -> same hit (pc[1:0] ignored).
REQ-034 BHT_EN: two not-taken updates on 0x100 -> counter 0, hit=1, pred_taken=0; three taken updates -> counter 3 (saturated), pred_taken=1; without macro, one not-taken update -> hit=0.
REQ-035 WAYS=2, INDEX_BITS=6: taken updates on 0x100, 0x200, 0x300 (same set 0) -> 0x100 evicted, 0x200 and 0x300 hit; a fourth, 0x400, evicts 0x200.
REQ-036 Fill entries, pulse flush -> flush_busy=1 for exactly 64 cycles, lookups miss, concurrent upd_en dropped; after sweep all lookups miss.
REQ-037 rst at flush cycle 10 -> next cycle flush_busy=0, all lookups miss, a new update allocates normally.
